// File: rtl/i2c_codec_cfg_seq_pkg.sv
// ---------------------------------------------------------------------------
// i2c_codec_cfg_seq_pkg
// Shared definitions for the codec configuration sequencer: the encodings
// of the I2C engine phase interface (txMode) and the sequencer FSM states.
// ---------------------------------------------------------------------------
package i2c_codec_cfg_seq_pkg;

  // Phase codes understood by the I2C transmit engine
  typedef enum logic [1:0] {
    MODE_START = 2'd0,
    MODE_BYTE  = 2'd1,
    MODE_STOP  = 2'd2,
    MODE_IDLE  = 2'd3
  } txModeT;

  // Sequencer states: one per engine phase plus the IDLE/NEXT bookkeeping
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_B0    = 3'd2,
    ST_B1    = 3'd3,
    ST_B2    = 3'd4,
    ST_STOP  = 3'd5,
    ST_NEXT  = 3'd6
  } seqStateT;

endpackage

// File: rtl/i2c_codec_cfg_seq_clk_div.sv
// ---------------------------------------------------------------------------
// i2c_clk_div
// Free-running divider that produces the engine bit clock and the update
// strobe used by the sequencer.
//   inClock  in   system clock
//   resetN   in   asynchronous active-low reset
//   txClock  out  inClock/CLK_DIV, 50% duty, registered, 1 after reset
//   update   out  high in the cycle whose closing edge makes txClock fall;
//                 every sequencer update happens on that edge
// ---------------------------------------------------------------------------
module i2c_clk_div #(
  parameter int CLK_DIV = 8
) (
  input  logic inClock,
  input  logic resetN,
  output logic txClock,
  output logic update
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

  logic [CW-1:0] divCnt;
  logic [CW-1:0] divNext;

  // Next counter value; txClock and the strobe are both decoded from it so
  // they line up exactly with the edge where divCnt takes that value
  always_comb begin
    divNext = (divCnt == LAST) ? '0 : divCnt + 1'b1;
  end

  assign update = (divNext == HALF);

  // The divider never stops, even while the sequencer is idle, so the
  // engine always sees a clean clock
  always_ff @(posedge inClock or negedge resetN) begin
    if (!resetN) begin
      divCnt  <= '0;
      txClock <= 1'b1;
    end else begin
      divCnt  <= divNext;
      txClock <= (divNext < HALF);
    end
  end

endmodule

// File: rtl/i2c_codec_cfg_seq.sv
// ---------------------------------------------------------------------------
// i2c_codec_cfg_seq
// Walks an external register table and, for every entry, drives the I2C
// transmit engine through START, device address, word high byte, word low
// byte and STOP. Also generates the engine's bit clock.
//   inClock    in   system clock
//   resetN     in   asynchronous active-low reset
//   start      in   one-cycle pulse, begins the sequence (ignored when busy)
//   tableAddr  out  table index;  tableData in  16-bit word at that index
//   txClock    out  engine clock
//   txMode     out  engine phase code;  txData out  byte to send
//   txReady    in   engine phase-done flag;  txAck in  slave ACKed last byte
//   busy/done/error out  status; done and error are sticky until next start
// Optional build macro I2C_CFG_RETRY_EN: a NACKed entry is retried up to
// MAX_RETRY times before error is raised. Without it the first NACK aborts.
// ---------------------------------------------------------------------------
module i2c_codec_cfg_seq
  import i2c_codec_cfg_seq_pkg::*;
#(
  parameter int          CLK_DIV  = 8,
  parameter logic [7:0]  DEV_ADDR = 8'h34,
  parameter int          NUM_REGS = 10
`ifdef I2C_CFG_RETRY_EN
  , parameter int        MAX_RETRY = 3
`endif
) (
  input  logic        inClock,
  input  logic        resetN,
  input  logic        start,
  output logic [7:0]  tableAddr,
  input  logic [15:0] tableData,
  output logic        txClock,
  output logic [1:0]  txMode,
  output logic [7:0]  txData,
  input  logic        txReady,
  input  logic        txAck,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_REGS - 1);

  logic        update;
  seqStateT    state;
  logic        startPend;
  logic        seenLow;
  logic        nackFlag;
  logic [15:0] dataReg;
  logic        phaseDone;
`ifdef I2C_CFG_RETRY_EN
  logic [1:0]  retryCnt;
`endif

  i2c_clk_div #(.CLK_DIV(CLK_DIV)) uDiv (
    .inClock (inClock),
    .resetN  (resetN),
    .txClock (txClock),
    .update  (update)
  );

  // A phase is finished only once the engine has been seen busy (ready low)
  // and then ready again, so a stale ready from the previous phase is ignored
  assign phaseDone = seenLow && txReady;

  // Main sequencer. The start pulse is captured at any edge, but all engine
  // facing outputs and state changes happen only on update edges (txClock
  // falling) so they are stable whenever the engine samples on the rise.
  always_ff @(posedge inClock or negedge resetN) begin
    if (!resetN) begin
      state     <= ST_IDLE;
      startPend <= 1'b0;
      seenLow   <= 1'b0;
      nackFlag  <= 1'b0;
      dataReg   <= '0;
      tableAddr <= '0;
      txMode    <= MODE_IDLE;
      txData    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef I2C_CFG_RETRY_EN
      retryCnt  <= '0;
`endif
    end else begin
      if (state == ST_IDLE && start && !startPend) begin
        startPend <= 1'b1;
        busy      <= 1'b1;
        done      <= 1'b0;
        error     <= 1'b0;
        tableAddr <= '0;
`ifdef I2C_CFG_RETRY_EN
        retryCnt  <= '0;
`endif
      end

      if (update) begin
        if (!txReady) seenLow <= 1'b1;
        case (state)
          ST_IDLE: begin
            if (startPend) begin
              startPend <= 1'b0;
              nackFlag  <= 1'b0;
              seenLow   <= 1'b0;
              txMode    <= MODE_START;
              state     <= ST_START;
            end
          end
          ST_START: begin
            if (phaseDone) begin
              seenLow <= 1'b0;
              dataReg <= tableData;
              txMode  <= MODE_BYTE;
              txData  <= DEV_ADDR;
              state   <= ST_B0;
            end
          end
          ST_B0, ST_B1, ST_B2: begin
            if (phaseDone) begin
              seenLow <= 1'b0;
              if (!txAck || state == ST_B2) begin
                if (!txAck) nackFlag <= 1'b1;
                txMode <= MODE_STOP;
                state  <= ST_STOP;
              end else if (state == ST_B0) begin
                txData <= dataReg[15:8];
                state  <= ST_B1;
              end else begin
                txData <= dataReg[7:0];
                state  <= ST_B2;
              end
            end
          end
          ST_STOP: begin
            if (phaseDone) begin
              seenLow <= 1'b0;
              txMode  <= MODE_IDLE;
              state   <= ST_NEXT;
            end
          end
          ST_NEXT: begin
`ifdef I2C_CFG_RETRY_EN
            if (nackFlag && retryCnt < 2'(MAX_RETRY)) begin
              retryCnt <= retryCnt + 1'b1;
              nackFlag <= 1'b0;
              seenLow  <= 1'b0;
              txMode   <= MODE_START;
              state    <= ST_START;
            end else
`endif
            if (nackFlag) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
`ifdef I2C_CFG_RETRY_EN
              retryCnt <= '0;
`endif
              if (tableAddr == LAST_IDX) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_IDLE;
              end else begin
                tableAddr <= tableAddr + 1'b1;
                seenLow   <= 1'b0;
                txMode    <= MODE_START;
                state     <= ST_START;
              end
            end
          end
          default: begin
            txMode <= MODE_IDLE;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_codec_cfg_seq.sv
// ---------------------------------------------------------------------------
// tb_i2c_codec_cfg_seq
// Directed bench for the codec configuration sequencer with a two-entry
// table and a small I2C engine model that logs every phase it executes.
// Expectations for the NACK tests follow the I2C_CFG_RETRY_EN build macro.
// ---------------------------------------------------------------------------
module tb_i2c_codec_cfg_seq;

  localparam int CLK_DIV  = 4;
  localparam int NUM_REGS = 2;

  logic        inClock;
  logic        resetN;
  logic        start;
  logic [7:0]  tableAddr;
  logic [15:0] tableData;
  logic        txClock;
  logic [1:0]  txMode;
  logic [7:0]  txData;
  logic        txReady = 1'b1;
  logic        txAck   = 1'b1;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  // Engine model state and phase log, entries are {mode, data}
  logic [9:0] engLog[$];
  int  engCnt    = 0;
  bit  engBusy   = 1'b0;
  int  byteIdx   = 0;
  int  nackCount = 0;
  int  nackLimit = 0;
  int  nackAddr  = 0;
  int  nackByte  = 0;

  int  doneRises = 0;
  int  modeChanges = 0;
  int  edgeViolations = 0;

  i2c_codec_cfg_seq #(
    .CLK_DIV  (CLK_DIV),
    .DEV_ADDR (8'h34),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .inClock   (inClock),
    .resetN    (resetN),
    .start     (start),
    .tableAddr (tableAddr),
    .tableData (tableData),
    .txClock   (txClock),
    .txMode    (txMode),
    .txData    (txData),
    .txReady   (txReady),
    .txAck     (txAck),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial begin
    inClock = 1'b0;
    forever #5 inClock = ~inClock;
  end

  // Combinational register table
  always_comb begin
    case (tableAddr)
      8'd0:    tableData = 16'h1E00;
      8'd1:    tableData = 16'h0C10;
      default: tableData = 16'hDEAD;
    endcase
  end

  // Engine model: on a txClock rise with no phase running it picks up the
  // presented mode, drops ready for two more rises, then raises it again.
  // The ACK answer is chosen when a byte starts, from the NACK plan.
  always @(posedge txClock or negedge resetN) begin
    if (!resetN) begin
      txReady = 1'b1;
      txAck   = 1'b1;
      engBusy = 1'b0;
      engCnt  = 0;
      byteIdx = 0;
    end else if (engBusy) begin
      engCnt = engCnt - 1;
      if (engCnt == 0) begin
        engBusy = 1'b0;
        txReady = 1'b1;
      end
    end else if (txMode != 2'd3) begin
      engBusy = 1'b1;
      engCnt  = 2;
      txReady = 1'b0;
      if (txMode == 2'd1) begin
        engLog.push_back({txMode, txData});
        if (int'(tableAddr) == nackAddr && byteIdx == nackByte && nackCount < nackLimit) begin
          txAck = 1'b0;
          nackCount = nackCount + 1;
        end else begin
          txAck = 1'b1;
        end
        byteIdx = byteIdx + 1;
      end else begin
        if (txMode == 2'd0) byteIdx = 0;
        engLog.push_back({txMode, 8'h00});
      end
    end
  end

  always @(posedge done) doneRises = doneRises + 1;

  // Watches that txMode/txData only move on the edge where txClock falls
  always @(posedge inClock) begin
    logic [1:0] prevMode;
    logic [7:0] prevData;
    logic       prevClk;
    logic       prevRst;
    #1;
    if (resetN && prevRst && (txMode !== prevMode || txData !== prevData)) begin
      modeChanges = modeChanges + 1;
      if (!(txClock == 1'b0 && prevClk == 1'b1)) edgeViolations = edgeViolations + 1;
    end
    prevMode = txMode;
    prevData = txData;
    prevClk  = txClock;
    prevRst  = resetN;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(negedge inClock) start = 1'b1;
    @(negedge inClock) start = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge inClock);
      n++;
    end
    #1;
    if (n >= budget) checkOutput("idle_timeout", 1, 0);
  endtask

  task automatic waitLog(input int target, input int budget);
    int n = 0;
    while (engLog.size() < target && n < budget) begin
      @(posedge inClock);
      n++;
    end
    if (n >= budget) checkOutput("log_timeout", 1, 0);
  endtask

  task automatic checkFullRun(input string tag, input int base);
    logic [9:0] expFull[10];
    expFull = '{10'h000, 10'h134, 10'h11E, 10'h100, 10'h200,
                10'h000, 10'h134, 10'h10C, 10'h110, 10'h200};
    checkOutput({tag, "_len"}, engLog.size() - base, 10);
    for (int i = 0; i < 10; i++)
      if (base + i < engLog.size())
        checkOutput($sformatf("%s_ph%0d", tag, i), engLog[base + i], expFull[i]);
  endtask

  function automatic int countStarts(input int base);
    int c = 0;
    for (int i = base; i < engLog.size(); i++)
      if (engLog[i][9:8] == 2'd0) c++;
    return c;
  endfunction

  initial begin
    int base;
    int dr;
    logic [9:0] expNack[4];
    resetN = 1'b0;
    start  = 1'b0;
    repeat (3) @(posedge inClock);
    #1;
    checkOutput("rst_txMode", txMode, 2'd3);
    checkOutput("rst_txData", txData, 8'h00);
    checkOutput("rst_tableAddr", tableAddr, 8'h00);
    checkOutput("rst_txClock", txClock, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_error", error, 1'b0);
    @(negedge inClock) resetN = 1'b1;

    $display("[TB] full run, extra start pulse during B1");
    base = engLog.size();
    dr = doneRises;
    applyStimulus();
    checkOutput("run_busy", busy, 1'b1);
    waitLog(base + 3, 2000);
    applyStimulus();
    waitIdle(4000);
    checkFullRun("run", base);
    checkOutput("run_done", done, 1'b1);
    checkOutput("run_busy_end", busy, 1'b0);
    checkOutput("run_error", error, 1'b0);
    checkOutput("run_tableAddr", tableAddr, 8'd1);
    checkOutput("run_done_rises", doneRises - dr, 1);

    $display("[TB] NACK on B1 of entry 0");
    nackAddr = 0; nackByte = 1; nackLimit = nackCount + 1;
    base = engLog.size();
    applyStimulus();
    waitIdle(4000);
    repeat (200) @(posedge inClock);
    #1;
    expNack = '{10'h000, 10'h134, 10'h11E, 10'h200};
`ifdef I2C_CFG_RETRY_EN
    checkOutput("nack0_done", done, 1'b1);
    checkOutput("nack0_starts", countStarts(base), 3);
`else
    checkOutput("nack0_len", engLog.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < engLog.size())
        checkOutput($sformatf("nack0_ph%0d", i), engLog[base + i], expNack[i]);
    checkOutput("nack0_error", error, 1'b1);
    checkOutput("nack0_done", done, 1'b0);
    checkOutput("nack0_tableAddr", tableAddr, 8'd0);
`endif

    $display("[TB] two NACKs on entry 1");
    nackAddr = 1; nackByte = 1; nackLimit = nackCount + 2;
    base = engLog.size();
    applyStimulus();
    waitIdle(6000);
`ifdef I2C_CFG_RETRY_EN
    checkOutput("retry2_len", engLog.size() - base, 18);
    checkOutput("retry2_starts", countStarts(base), 4);
    checkOutput("retry2_done", done, 1'b1);
    checkOutput("retry2_error", error, 1'b0);
`else
    checkOutput("retry2_len", engLog.size() - base, 9);
    checkOutput("retry2_done", done, 1'b0);
    checkOutput("retry2_error", error, 1'b1);
    checkOutput("retry2_tableAddr", tableAddr, 8'd1);
`endif

    $display("[TB] four NACKs on entry 1");
    nackLimit = nackCount + 4;
    base = engLog.size();
    applyStimulus();
    waitIdle(8000);
`ifdef I2C_CFG_RETRY_EN
    checkOutput("retry4_len", engLog.size() - base, 21);
    checkOutput("retry4_starts", countStarts(base), 5);
`else
    checkOutput("retry4_len", engLog.size() - base, 9);
`endif
    checkOutput("retry4_error", error, 1'b1);
    checkOutput("retry4_done", done, 1'b0);
    nackLimit = nackCount;

    $display("[TB] reset during B2");
    base = engLog.size();
    applyStimulus();
    waitLog(base + 4, 2000);
    repeat (2) @(negedge inClock);
    resetN = 1'b0;
    repeat (2) @(negedge inClock);
    checkOutput("mid_rst_txMode", txMode, 2'd3);
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_txClock", txClock, 1'b1);
    checkOutput("mid_rst_tableAddr", tableAddr, 8'd0);
    resetN = 1'b1;
    repeat (3) @(negedge inClock);
    base = engLog.size();
    dr = doneRises;
    applyStimulus();
    waitIdle(4000);
    checkFullRun("rerun", base);
    checkOutput("rerun_done", done, 1'b1);
    checkOutput("rerun_error", error, 1'b0);
    checkOutput("rerun_done_rises", doneRises - dr, 1);

    checkOutput("edge_align", edgeViolations, 0);
    checkOutput("mode_changes_seen", (modeChanges > 20) ? 1 : 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_codec_cfg_seq.md
Name: i2c_codec_cfg_seq

Overview:
Sequencer that configures the audio codec over I2C by driving the I2C transmit engine's phase interface (mode/data/ready/ack).
- For each entry of an external register table it issues START, three bytes (device address, word high byte, word low byte) and STOP.
- Also generates the engine's bit clock.
- Sits between the top-level audio init logic and the I2C transmit engine.

Parameters:
CLK_DIV, 8, inClock cycles per txClock period; even, >=4.
DEV_ADDR, 8'h34, I2C write address byte (7-bit address plus R/W=0).
NUM_REGS, 10, number of table entries to send (1..256).
MAX_RETRY, 3, retries per entry on NACK (used only with the optional feature).

Ports:
inClock  in  1  system clock.
resetN  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse: begin the configuration sequence.
tableAddr  out  8  table entry index.
tableData  in  16  table word; combinational ROM, valid in the same cycle as tableAddr.
txClock  out  1  engine clock, inClock/CLK_DIV, 50% duty.
txMode  out  2  0=start, 1=byte, 2=stop, 3=idle (engine holds lines).
txData  out  8  byte to send.
txReady  in  1  engine phase-done flag, in txClock domain.
txAck  in  1  1 = slave ACKed the last byte.
busy  out  1  sequence in progress.
done  out  1  sticky: all entries sent OK; cleared by start.
error  out  1  sticky: NACK abort; cleared by start.

Behaviour:
- Reset values: txMode=3, txData=0, tableAddr=0, txClock=1, busy=0, done=0, error=0. The divider counter divCnt=0 and the FSM is in IDLE.
- Divider:
  - divCnt counts 0..CLK_DIV-1 and wraps.
  - txClock (registered) is 1 while divCnt < CLK_DIV/2, else 0.
  - The divider runs continuously, including in IDLE.
- Update point: the inClock edge where divCnt becomes CLK_DIV/2 (txClock falling edge).
  - txReady and txAck are sampled only at this point.
  - txMode, txData and FSM transitions change only at this point.
  - Outputs therefore stay stable across every txClock rising edge.
- Phase handshake:
  - On issuing a phase, clear flag seenLow.
  - At an update point with txReady=0, set seenLow.
  - The phase is complete at the first update point with seenLow=1 and txReady=1.
  - The next phase's txMode is presented at that same update point, so the engine never repeats a phase.
- FSM states and transitions:
  - IDLE: start pulse sets busy=1, clears done and error, sets tableAddr=0, goes to START. start is ignored in every other state.
  - START: txMode=0. When the phase completes go to B0 with txData=DEV_ADDR.
  - B0, B1, B2: txMode=1.
    - B0 sends DEV_ADDR; B1 sends tableData[15:8]; B2 sends tableData[7:0].
    - tableData is latched into a 16-bit register on leaving START.
    - On completion, txAck=1 advances to the next state; txAck=0 sets nackFlag and goes to STOP.
  - STOP: txMode=2. On completion go to NEXT.
  - NEXT: txMode=3 for one update point.
    - If nackFlag is set: error=1, busy=0, go to IDLE.
    - Else if tableAddr==NUM_REGS-1: done=1, busy=0, go to IDLE.
    - Else tableAddr+1, go to START.
- Timing: each entry takes at least 3+3*36+3+1 = 115 txClock periods.
- tableAddr is 8 bits and never wraps, since NUM_REGS<=256.
- Reset mid-transaction returns immediately to the reset values; no STOP is issued. The engine is reset by the same resetN.

Optional Feature:
Macro I2C_CFG_RETRY_EN.
- Defined: a NACK on an entry goes to STOP, then retries the same entry, up to MAX_RETRY times. A 2-bit retry counter is cleared on every successful entry. error is set only when retries are exhausted.
- Undefined: the first NACK sets error and aborts the sequence. The retry counter and MAX_RETRY logic are absent.

Decomposition:
- Shared package: txMode encodings (MODE_START=0, MODE_BYTE=1, MODE_STOP=2, MODE_IDLE=3) and the FSM state encoding.
- One natural sub-module: i2c_clk_div, which produces divCnt, txClock and the update-point strobe.

Test Plan:
1. Bus model ACKs every byte; NUM_REGS=2; table {16'h1E00, 16'h0C10}; start pulse. Required: engine observes bytes 34,1E,00 then 34,0C,10, each framed by START/STOP. done=1, busy=0, error=0.
2. NACK on B1 of entry 0 with the macro undefined. Required: STOP follows immediately, error=1, done=0, tableAddr=0, and no further START.
3. With I2C_CFG_RETRY_EN and MAX_RETRY=3: NACK the first two attempts of entry 1, then ACK. Required: 3 START/34/../STOP frames for entry 1, then done=1. With a NACK on 4 attempts: error=1.
4. Pulse start while busy in B1. Required: ignored; the sequence completes unchanged and done rises once.
5. Deassert resetN during B2 and release it. Required: txMode=3, busy=0, txClock=1 within the reset. A new start then runs the full sequence from tableAddr=0.
6. CLK_DIV=4. Required: txMode/txData transitions occur only when txClock falls, and never within one inClock cycle of a txClock rising edge.
